// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage and its multiply/divide unit.
//   md_op encodings (RV32M funct3 order), M-unit FSM states, ALU operation
//   codes and forwarding-mux select constants.
package ex_pkg;

  // M-extension operations
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // ALU operations
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Forwarding-mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MUL, MULH, MULHSU and MULHU all have op[2] clear
  function automatic logic is_mul(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative RV32M multiply/divide engine.
//   One shift-add or restoring-subtract step per cycle on operand magnitudes,
//   sign fixup on the final step. Divide-by-zero and signed overflow finish
//   straight from IDLE. Build option MD_FAST_MUL_EN gives multiplies a
//   single-cycle array path.
// Ports: clk, rst (sync, active-high); start/abort/hold handshake; op, a, b
//   operands; stall_c (combinational stall request), done_c (result valid
//   this cycle), res (registered result).
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall_c,
  output logic            done_c,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi, lo, bmag;
  logic [2:0]       op_q;
  logic             q_neg, r_neg;

  // Operand signedness and magnitudes for the incoming op
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    a_sgn    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_sgn    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_sgn & a[XLEN-1];
    b_neg    = b_sgn & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == MIN_VAL) && (b == '1);
    // op[1] selects the remainder within the divide group
    if (div_zero) fast_res = op[1] ? a : '1;
    else          fast_res = op[1] ? '0 : MIN_VAL;
  end

`ifdef MD_FAST_MUL_EN
  // Sign/zero-extend to 2*XLEN so the low half of the product is exact
  logic [2*XLEN-1:0] fa, fb, fprod;
  logic [XLEN-1:0]   fmul_res;
  always_comb begin
    fa       = a_sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    fb       = b_sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    fprod    = fa * fb;
    fmul_res = (op == MD_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`endif

  // One iteration step plus the sign-corrected result of the last step
  logic [XLEN:0]     mul_sum, div_t;
  logic [XLEN+1:0]   div_d;
  logic [XLEN-1:0]   nhi, nlo, fin;
  logic [2*XLEN-1:0] prod_fix;
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : '0);
    div_t   = {hi, lo[XLEN-1]};
    div_d   = {1'b0, div_t} - {2'b0, bmag};
    if (is_mul(op_q)) begin
      nhi = XLEN'(mul_sum >> 1);
      nlo = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!div_d[XLEN+1]) begin
      nhi = XLEN'(div_d);
      nlo = {lo[XLEN-2:0], 1'b1};
    end else begin
      nhi = XLEN'(div_t);
      nlo = {lo[XLEN-2:0], 1'b0};
    end
    prod_fix = q_neg ? -{nhi, nlo} : {nhi, nlo};
    case (op_q)
      MD_MUL:                      fin = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             fin = q_neg ? -nlo : nlo;
      default:                     fin = r_neg ? -nhi : nhi;
    endcase
  end

  // M-unit FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      res   <= '0;
      hi    <= '0;
      lo    <= '0;
      bmag  <= '0;
      op_q  <= MD_MUL;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q  <= op;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            bmag  <= b_mag;
            hi    <= '0;
            lo    <= a_mag;
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              res   <= fast_res;
              state <= MD_DONE;
            end
`ifdef MD_FAST_MUL_EN
            else if (is_mul(op)) begin
              res   <= fmul_res;
              state <= MD_DONE;
            end
`endif
            else begin
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (abort) begin
            state <= MD_IDLE;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              res   <= fin;
              state <= MD_DONE;
            end
          end
        end
        MD_DONE: begin
          // Frozen while the rest of the pipeline is held
          if (abort || !hold) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign stall_c = !rst && (((state == MD_IDLE) && start) || ((state == MD_BUSY) && !abort));
  assign done_c  = (state == MD_DONE) && !abort && !hold;

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding, ALU, branch target adder,
//   EX/MEM control flush and an iterative RV32M multiply/divide unit.
//   Optional build macro MD_FAST_MUL_EN: single-cycle multiplies.
// Ports: clk, rst (sync, active-high); flush/hit/npu_stall pipeline control;
//   ID/EX operands and controls; forwarding indices/data from EX/MEM and
//   MEM/WB; outputs t_addr, result, f_b, zero, f_ex_ctrl, ex_stall, md_done.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hit,
  input  logic              npu_stall,
  input  logic              op_valid,
  input  logic [CTRL_W-1:0] ex_ctrl_in,
  input  logic              alu_src,
  input  logic [3:0]        alu_ctrl,
  input  logic              en_npu,
  input  logic              md_en,
  input  logic [2:0]        md_op,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        ex_mem_rd,
  input  logic [4:0]        mem_wb_rd,
  input  logic              ex_mem_regwrite,
  input  logic              mem_wb_regwrite,
  input  logic [XLEN-1:0]   ex_mem_fwd,
  input  logic [XLEN-1:0]   wb_fwd,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  output logic [XLEN-1:0]   t_addr,
  output logic [XLEN-1:0]   result,
  output logic [XLEN-1:0]   f_b,
  output logic              zero,
  output logic [CTRL_W-1:0] f_ex_ctrl,
  output logic              ex_stall,
  output logic              md_done
);

  // Forwarding unit: EX/MEM has priority over MEM/WB
  logic [1:0] fwd_a, fwd_b;
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs1))      fwd_a = FWD_MEM;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs1)) fwd_a = FWD_WB;
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs2))      fwd_b = FWD_MEM;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs2)) fwd_b = FWD_WB;
  end

  logic [XLEN-1:0] f_a, alu_b, alu_res, md_res;
  always_comb begin
    case (fwd_a)
      FWD_MEM: f_a = ex_mem_fwd;
      FWD_WB:  f_a = wb_fwd;
      default: f_a = rd1;
    endcase
    case (fwd_b)
      FWD_MEM: f_b = ex_mem_fwd;
      FWD_WB:  f_b = wb_fwd;
      default: f_b = rd2;
    endcase
    alu_b = alu_src ? imm : f_b;
  end

  // ALU; NPU mode clamps negative results to zero (ReLU activation)
  logic [CNT_W-1:0] shamt;
  always_comb begin
    shamt = alu_b[CNT_W-1:0];
    case (alu_ctrl)
      ALU_AND:  alu_res = f_a & alu_b;
      ALU_OR:   alu_res = f_a | alu_b;
      ALU_ADD:  alu_res = f_a + alu_b;
      ALU_XOR:  alu_res = f_a ^ alu_b;
      ALU_SLL:  alu_res = f_a << shamt;
      ALU_SRL:  alu_res = f_a >> shamt;
      ALU_SUB:  alu_res = f_a - alu_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(f_a) < $signed(alu_b))};
      ALU_SRA:  alu_res = $unsigned($signed(f_a) >>> shamt);
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (f_a < alu_b)};
      default:  alu_res = '0;
    endcase
    if (en_npu && alu_res[XLEN-1]) alu_res = '0;
  end

  ex_muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_md (
    .clk     (clk),
    .rst     (rst),
    .start   (op_valid && md_en && !flush),
    .abort   (flush),
    .hold    (npu_stall || !hit),
    .op      (md_op),
    .a       (f_a),
    .b       (f_b),
    .stall_c (ex_stall),
    .done_c  (md_done),
    .res     (md_res)
  );

  assign zero      = (alu_res == '0);
  assign result    = md_done ? md_res : alu_res;
  assign t_addr    = pc + (imm << 1);
  // Bubble into EX/MEM on any flush, hold or stall
  assign f_ex_ctrl = (rst || flush || !hit || npu_stall || ex_stall) ? '0 : ex_ctrl_in;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed self-checking bench for ex_stage_md (XLEN=32).
module tb_ex_stage_md;
  import ex_pkg::*;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_STALLS = 1;
`else
  localparam int MUL_STALLS = 33;
`endif
  localparam logic [4:0] CTRL = 5'h15;

  logic        clk, rst, flush, hit, npu_stall, op_valid;
  logic [4:0]  ex_ctrl_in;
  logic        alu_src, en_npu, md_en;
  logic [3:0]  alu_ctrl;
  logic [2:0]  md_op;
  logic [31:0] pc, imm, ex_mem_fwd, wb_fwd, rd1, rd2;
  logic [4:0]  rs1, rs2, ex_mem_rd, mem_wb_rd;
  logic        ex_mem_regwrite, mem_wb_regwrite;
  logic [31:0] t_addr, result, f_b;
  logic        zero, ex_stall, md_done;
  logic [4:0]  f_ex_ctrl;

  int checks   = 0;
  int failures = 0;

  ex_stage_md dut (
    .clk(clk), .rst(rst), .flush(flush), .hit(hit), .npu_stall(npu_stall),
    .op_valid(op_valid), .ex_ctrl_in(ex_ctrl_in), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .en_npu(en_npu), .md_en(md_en), .md_op(md_op),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2), .ex_mem_rd(ex_mem_rd),
    .mem_wb_rd(mem_wb_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_regwrite(mem_wb_regwrite), .ex_mem_fwd(ex_mem_fwd),
    .wb_fwd(wb_fwd), .rd1(rd1), .rd2(rd2), .t_addr(t_addr), .result(result),
    .f_b(f_b), .zero(zero), .f_ex_ctrl(f_ex_ctrl), .ex_stall(ex_stall),
    .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one M-op with no forwarding, wait (bounded) for md_done
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
    int          stalls;
    logic        seen;
    logic [31:0] got;
    logic [4:0]  ctl;
    stalls = 0; seen = 1'b0; got = '0; ctl = '0;
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
    rs1 = 5'd1; rs2 = 5'd2; rd1 = a; rd2 = b;
    md_op = op; md_en = 1'b1; op_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (md_done) begin
        seen = 1'b1; got = result; ctl = f_ex_ctrl;
      end else if (ex_stall) begin
        stalls++;
      end
      step();
      if (seen) break;
    end
    op_valid = 1'b0; md_en = 1'b0;
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_res"}, 64'(got), 64'(exp_res));
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    chk({tag, "_ctrl"}, 64'(ctl), 64'(CTRL));
  endtask

  initial begin
    int dcount;
    rst = 1'b1; flush = 1'b0; hit = 1'b1; npu_stall = 1'b0; op_valid = 1'b0;
    ex_ctrl_in = CTRL; alu_src = 1'b0; alu_ctrl = ALU_ADD; en_npu = 1'b0;
    md_en = 1'b0; md_op = MD_MUL; pc = 32'h1000; imm = 32'h10;
    rs1 = '0; rs2 = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
    ex_mem_fwd = '0; wb_fwd = '0; rd1 = '0; rd2 = '0;

    // Reset state
    step(); step();
    #1;
    chk("rst_stall", 64'(ex_stall), 64'd0);
    chk("rst_done", 64'(md_done), 64'd0);
    chk("rst_ctrl", 64'(f_ex_ctrl), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ctrl", 64'(f_ex_ctrl), 64'(CTRL));
    chk("t_addr", 64'(t_addr), 64'h1020);

    // Forwarding priority and rd=0 rule
    rs1 = 5'd5; rs2 = 5'd6; ex_mem_rd = 5'd5; mem_wb_rd = 5'd5;
    ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1;
    ex_mem_fwd = 32'd100; wb_fwd = 32'd200; rd1 = 32'd300; rd2 = 32'd7;
    #1;
    chk("fwd_mem", 64'(result), 64'd107);
    chk("fwd_fb_rf", 64'(f_b), 64'd7);
    ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
    #1;
    chk("fwd_rd0", 64'(result), 64'd307);
    mem_wb_rd = 5'd5;
    #1;
    chk("fwd_wb", 64'(result), 64'd207);
    ex_mem_rd = 5'd5; rs2 = 5'd5;
    #1;
    chk("fwd_both", 64'(result), 64'd200);
    chk("fwd_fb_mem", 64'(f_b), 64'd100);
    alu_src = 1'b1; alu_ctrl = ALU_SUB;
    #1;
    chk("sub_imm", 64'(result), 64'd84);
    chk("sub_imm_zero", 64'(zero), 64'd0);
    imm = 32'd100;
    #1;
    chk("zero_flag", 64'(zero), 64'd1);
    alu_src = 1'b0; alu_ctrl = ALU_ADD; ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
    rd1 = 32'd3; rd2 = 32'hFFFF_FFFB;
    #1;
    chk("add_neg", 64'(result), 64'hFFFF_FFFE);
    en_npu = 1'b1;
    #1;
    chk("npu_relu", 64'(result), 64'd0);
    en_npu = 1'b0;
    npu_stall = 1'b1;
    #1;
    chk("npu_stall_ctrl", 64'(f_ex_ctrl), 64'd0);
    npu_stall = 1'b0; hit = 1'b0;
    #1;
    chk("miss_ctrl", 64'(f_ex_ctrl), 64'd0);
    hit = 1'b1;
    step();

    // Divide and remainder
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_md("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_md("div_z", MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("rem_z", MD_REM, 32'd5, 32'd0, 32'd5, 1);

    // Multiplies
    run_md("mul", MD_MUL, 32'd7, 32'd6, 32'd42, MUL_STALLS);
    run_md("mulh", MD_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALLS);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, MUL_STALLS);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALLS);

    // Flush ten cycles into a divide
    rs1 = 5'd1; rs2 = 5'd2; rd1 = 32'd1000; rd2 = 32'd3;
    md_op = MD_DIV; md_en = 1'b1; op_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    #1;
    chk("flush_pre_stall", 64'(ex_stall), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(ex_stall), 64'd0);
    chk("flush_ctrl", 64'(f_ex_ctrl), 64'd0);
    step();
    flush = 1'b0; op_valid = 1'b0; md_en = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (md_done) dcount++;
      step();
    end
    chk("flush_no_done", 64'(dcount), 64'd0);
    chk("flush_idle_stall", 64'(ex_stall), 64'd0);
    run_md("mul_after_flush", MD_MUL, 32'd12, 32'd11, 32'd132, MUL_STALLS);

    // Reset mid-divide
    rd1 = 32'd100; rd2 = 32'd7; md_op = MD_DIVU; md_en = 1'b1; op_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; md_en = 1'b0; op_valid = 1'b0;
    step();
    #1;
    chk("midrst_stall", 64'(ex_stall), 64'd0);
    chk("midrst_done", 64'(md_done), 64'd0);
    chk("midrst_ctrl", 64'(f_ex_ctrl), 64'd0);
    rst = 1'b0;
    step();
    run_md("divu_after_rst", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
Parametrised successor execute stage for the RISC-V/NPU pipeline.
- Keeps the existing EX datapath: forwarding unit, forwarding muxes, ALU-source mux, ALU, branch target adder and EX/MEM control flush.
- Adds an iterative RV32M multiply/divide engine with a stall handshake back to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- XLEN, 32, datapath width (power of two, 16..64).
- CTRL_W, 5, width of the EX control bundle passed to EX/MEM.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch/jump flush
- hit  in  1  cache hit; 0 forces an EX/MEM bubble
- npu_stall  in  1  NPU busy; forces an EX/MEM bubble
- op_valid  in  1  ID/EX holds a real instruction
- ex_ctrl_in  in  CTRL_W  EX control bundle
- alu_src  in  1  1 selects imm as the ALU B operand
- alu_ctrl  in  4  ALU operation
- en_npu  in  1  NPU ALU mode
- md_en  in  1  instruction is an M-extension operation
- md_op  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (ex_pkg encoding)
- pc  in  XLEN  instruction PC
- imm  in  XLEN  ImmGen output
- rs1, rs2  in  5  source register indices
- ex_mem_rd, mem_wb_rd  in  5  destination register indices
- ex_mem_regwrite, mem_wb_regwrite  in  1  write enables
- ex_mem_fwd, wb_fwd  in  XLEN  forwarding data
- rd1, rd2  in  XLEN  register file data
- t_addr  out  XLEN  branch target, pc + (imm << 1)
- result  out  XLEN  ALU or M-unit result
- f_b  out  XLEN  forwarded rs2 value (store data)
- zero  out  1  ALU zero flag
- f_ex_ctrl  out  CTRL_W  control bundle to EX/MEM
- ex_stall  out  1  freezes PC, IF/ID and ID/EX
- md_done  out  1  M-unit result valid this cycle

Behaviour:
- Forwarding:
  - EX/MEM source wins over MEM/WB.
  - A source is used only if its regwrite=1, its rd!=0 and its rd equals rs1/rs2.
  - Otherwise rd1/rd2 pass through.
- ALU path is combinational, unchanged: zero = (ALU result == 0).
- result selection: md_done ? md_res : ALU result.
- M-unit FSM states: IDLE, BUSY, DONE. All state and registers are cleared by rst.
- Reset values:
  - state=IDLE, cnt=0, md_res=0.
  - ex_stall=0, md_done=0.
  - f_ex_ctrl=0 while rst is high.
- IDLE:
  - Start condition: op_valid & md_en & !flush.
  - On start, ex_stall=1 combinationally in the same cycle.
  - Latch forwarded A/B, magnitudes, result sign and op.
  - Go to BUSY with cnt=0.
- IDLE fast paths (go straight to DONE, skipping BUSY):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- BUSY:
  - One shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle.
  - cnt increments each step; at cnt==XLEN-1, go to DONE.
  - ex_stall=1 throughout.
- DONE:
  - md_res is final (sign-corrected; MULH* returns the upper XLEN bits of the 2*XLEN product).
  - md_done=1 and ex_stall=0 for exactly one cycle, then IDLE.
  - The held instruction is not re-issued, because the pipeline advances at this edge.
- Latency: the iterative op occupies EX for XLEN+2 cycles, with ex_stall high for XLEN+1 of them. Fast paths take 2 cycles.
- flush while in BUSY or DONE:
  - Abort to IDLE next cycle; md_done stays 0.
  - ex_stall drops combinationally in the flush cycle.
- f_ex_ctrl = 0 when any of: flush, !hit, npu_stall, ex_stall. Otherwise f_ex_ctrl = ex_ctrl_in.
- The M-unit ignores npu_stall and hit while BUSY; it stays frozen in DONE until both are clear.

Optional Feature:
MD_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle array multiply.
  - Path is IDLE->DONE, registered into md_res.
  - 2-cycle occupancy, 1 stall cycle.
- Undefined: multiplies use the iterative XLEN-cycle path.
- Division is always iterative.

Decomposition:
- ex_pkg holds:
  - md_op encodings and the md_state_t enum (IDLE/BUSY/DONE).
  - Forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, ex_muldiv_iter: FSM, counter, shift registers and sign fixup, with start/abort/done handshake.
- Forwarding and ALU logic stay inline.

Test Plan:
1. Back-to-back add with rs1 = ex_mem_rd = mem_wb_rd = 5, both regwrite=1 -> ex_mem_fwd is chosen. Repeat with rd=0 -> rd1 is chosen.
2. DIVU 100/7 (XLEN=32) -> ex_stall high for 33 cycles, then md_done with result=14. REMU 100/7 -> result=2.
3. DIV 0x80000000 / 0xFFFFFFFF -> 2-cycle fast path, result=0x80000000. DIV 5/0 -> result=0xFFFFFFFF. REM 5/0 -> result=5.
4. MULH 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFF. MULHU on the same operands -> 0x00000001. Check latency with and without MD_FAST_MUL_EN.
5. flush asserted 10 cycles into a DIV -> ex_stall drops that cycle, md_done never asserts, f_ex_ctrl=0, next MUL runs correctly.
6. rst pulsed mid-BUSY -> all outputs return to reset values next cycle. npu_stall=1 or hit=0 with an ALU op -> f_ex_ctrl=0.
